// File: rtl/arbitro_division.sv
// Arbiter that shares one multi-cycle divider between requesters A and B.
// Round-robin on ties, latched operands, rising-edge completion, timeout abort.
module arbitro_division #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             validoA,
    input  logic [WIDTH-1:0] dividendoA,
    input  logic [WIDTH-1:0] divisorA,
    output logic             listoA,
    input  logic             validoB,
    input  logic [WIDTH-1:0] dividendoB,
    input  logic [WIDTH-1:0] divisorB,
    output logic             listoB,
    output logic             divStart,
    output logic [WIDTH-1:0] divDividendo,
    output logic [WIDTH-1:0] divDivisor,
    input  logic             divisionLista,
    input  logic [WIDTH-1:0] divCociente,
    input  logic [WIDTH-1:0] divResto,
    output logic [WIDTH-1:0] salida,
    output logic [WIDTH-1:0] resto,
    output logic             validoS,
    output logic             idS,
    output logic             errorDiv
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    // WAIT lasts TIMEOUT cycles at most; the counter starts at 0 in the first WAIT cycle.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] dividendo_q, dividendo_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             lista_prev_q, lista_prev_d;
    logic [WIDTH-1:0] salida_q, salida_d;
    logic [WIDTH-1:0] resto_q, resto_d;
    logic             ids_q, ids_d;
    logic             error_q, error_d;

    logic             grant_b;
    logic             listo_a, listo_b;
    logic             lista_edge;
    logic [WIDTH-1:0] sel_dividendo, sel_divisor;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        dividendo_d  = dividendo_q;
        divisor_d    = divisor_q;
        cnt_d        = cnt_q;
        lista_prev_d = divisionLista;
        salida_d     = salida_q;
        resto_d      = resto_q;
        ids_d        = ids_q;
        error_d      = error_q;
        listo_a      = 1'b0;
        listo_b      = 1'b0;
        lista_edge   = divisionLista & ~lista_prev_q;
        // B wins when alone, or on a tie when A was served last.
        grant_b       = validoB & (~validoA | ~last_grant_q);
        sel_dividendo = grant_b ? dividendoB : dividendoA;
        sel_divisor   = grant_b ? divisorB   : divisorA;

        case (state_q)
            ST_IDLE: begin
                if (validoA || validoB) begin
                    listo_a      = ~grant_b;
                    listo_b      = grant_b;
                    last_grant_d = grant_b;
                    id_d         = grant_b;
                    dividendo_d  = sel_dividendo;
                    divisor_d    = sel_divisor;
                    if (sel_divisor == '0) begin
                        salida_d = '1;
                        resto_d  = sel_dividendo;
                        ids_d    = grant_b;
                        error_d  = 1'b1;
                        state_d  = ST_OUT;
                    end else begin
                        state_d  = ST_START;
                    end
                end
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (lista_edge) begin
                    salida_d = divCociente;
                    resto_d  = divResto;
                    ids_d    = id_q;
                    error_d  = 1'b0;
                    state_d  = ST_OUT;
                end else if (cnt_q == CNT_LAST) begin
                    salida_d = '0;
                    resto_d  = '0;
                    ids_d    = id_q;
                    error_d  = 1'b1;
                    state_d  = ST_OUT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            dividendo_q  <= '0;
            divisor_q    <= '0;
            cnt_q        <= '0;
            lista_prev_q <= 1'b0;
            salida_q     <= '0;
            resto_q      <= '0;
            ids_q        <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            dividendo_q  <= dividendo_d;
            divisor_q    <= divisor_d;
            cnt_q        <= cnt_d;
            lista_prev_q <= lista_prev_d;
            salida_q     <= salida_d;
            resto_q      <= resto_d;
            ids_q        <= ids_d;
            error_q      <= error_d;
        end
    end

    assign listoA       = listo_a;
    assign listoB       = listo_b;
    assign divStart     = (state_q == ST_START);
    assign divDividendo = dividendo_q;
    assign divDivisor   = divisor_q;
    assign salida       = salida_q;
    assign resto        = resto_q;
    assign idS          = ids_q;
    assign validoS      = (state_q == ST_OUT);
    assign errorDiv     = (state_q == ST_OUT) & error_q;

endmodule
